fft_butterfly_stage: RTL and testbench
======================================

// Module: fft_butterfly_stage
// PURPOSE
//  Radix-2 DIT butterfly for the 16-point FFT datapath, with twiddle multiply and 1/2 scaling.
//  Takes one complex pair (a, b) and twiddle w; produces out0 = (a + b*w)/2 and out1 = (a - b*w)/2.
//  Sits directly upstream of the 4-word pair register. It drives that register's data inputs and
//  its rising-edge write strobe 'we'.
//  Counts butterflies per FFT stage and flags stage completion to the sequencer.
// PARAMETERS
//  WORD_SIZE       16  signed two's-complement width of every re/im sample and twiddle
//  FRAC_BITS       14  twiddle fraction bits (Q1.14: 16384 = +1.0)
//  BFLY_PER_STAGE   8  butterflies per FFT stage (N/2 for N=16)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input pair + twiddle valid this cycle
//  in_ready   out  1          block can accept this cycle
//  in0_re     in   WORD_SIZE  a real
//  in0_im     in   WORD_SIZE  a imag
//  in1_re     in   WORD_SIZE  b real
//  in1_im     in   WORD_SIZE  b imag
//  tw_re      in   WORD_SIZE  twiddle real, Q1.FRAC_BITS
//  tw_im      in   WORD_SIZE  twiddle imag, Q1.FRAC_BITS
//  out0_re    out  WORD_SIZE  (a + b*w)/2 real, registered
//  out0_im    out  WORD_SIZE  (a + b*w)/2 imag, registered
//  out1_re    out  WORD_SIZE  (a - b*w)/2 real, registered
//  out1_im    out  WORD_SIZE  (a - b*w)/2 imag, registered
//  out_valid  out  1          one-cycle pulse: out* updated at this edge
//  we         out  1          one-cycle write strobe to pair register, 1 cycle after out_valid
//  stage_done out  1          one-cycle pulse coincident with the BFLY_PER_STAGE-th 'we'
// BEHAVIOUR
//  Reset (rst_n low, async): all out* = 0, out_valid/we/stage_done = 0, in_ready = 1.
//   Pipeline valids and butterfly counter are cleared; in-flight data is discarded and never
//   produces 'we'.
//  Accept: transfer occurs on an edge where in_valid && in_ready.
//   in_ready is a register: 0 for exactly the one cycle after each accept, else 1.
//   This caps throughput at one butterfly per 2 cycles, so 'we' always returns low between
//   pulses (downstream latches on the we rising edge).
//  Pipeline (accept at edge k):
//   S1 @k:   register a, and products pr = b_re*w_re, pi = b_im*w_im, qr = b_re*w_im, qi = b_im*w_re
//            (full 2*WORD_SIZE signed).
//   S2 @k+1: bw_re = pr - pi, bw_im = qr + qi (2*WORD_SIZE+1 bits).
//            Round by adding 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS, then saturate
//            to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
//   S3 @k+2: out0 = (a + bw) >>> 1, out1 = (a - bw) >>> 1.
//            Computed in WORD_SIZE+1 bits, truncating shift; the result always fits, no saturation.
//            out* register, out_valid = 1 for that cycle.
//   @k+3:    we = 1 for one cycle; out* hold until the next S3 update (>= 2 cycles later).
//  Latency: accept edge to out* update = 2 cycles; accept edge to we rise = 3 cycles.
//  Counter: increments on each 'we'. On the 'we' with count == BFLY_PER_STAGE-1, stage_done = 1
//   in the same cycle and count wraps to 0.
//  in_valid while in_ready = 0: ignored, not accepted; the source holds data until accepted.
//  Reset asserted mid-pipeline: no out_valid, we or stage_done may follow reset deassertion
//   until a new accept.
// TESTING
//  1. Identity twiddle: a=(1000,200), b=(400,-100), w=(16384,0)
//     -> out0=(700,50), out1=(300,150); out_valid 2 cycles after accept edge, we 1 cycle later.
//  2. -j twiddle: a=(0,0), b=(400,-100), w=(0,-16384)
//     -> b*w=(-100,-400); out0=(-50,-200), out1=(50,200).
//  3. Saturation: a=(0,0), b=(-32768,-32768), w=(16384,-16384)
//     -> bw_re saturates -32768, bw_im=0; out0=(-16384,0), out1=(16384,0).
//  4. Throughput: hold in_valid=1 for 16 cycles -> exactly 8 accepts (in_ready alternates 1,0).
//     -> 8 single-cycle we pulses each separated by >=1 low cycle; stage_done with the 8th we only.
//  5. Reset mid-flight: accept a pair, assert rst_n=0 one cycle later for 1 cycle
//     -> all outputs 0; no we for 10 cycles after release; next stage_done needs 8 fresh butterflies.
//  6. Stalled source: in_valid pulses every 5 cycles with distinct data
//     -> each result appears once, in order, with we pulse 3 cycles after its accept edge.

Source files
------------

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly: (a +/- b*w)/2 with Q1.FRAC_BITS twiddle, 3-stage pipeline,
// a delayed write strobe for the pair register, and a per-stage butterfly counter.
module fft_butterfly_stage #(
   parameter int WORD_SIZE      = 16,
   parameter int FRAC_BITS      = 14,
   parameter int BFLY_PER_STAGE = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WORD_SIZE-1:0] in0_re,
   input  logic signed [WORD_SIZE-1:0] in0_im,
   input  logic signed [WORD_SIZE-1:0] in1_re,
   input  logic signed [WORD_SIZE-1:0] in1_im,
   input  logic signed [WORD_SIZE-1:0] tw_re,
   input  logic signed [WORD_SIZE-1:0] tw_im,
   output logic signed [WORD_SIZE-1:0] out0_re,
   output logic signed [WORD_SIZE-1:0] out0_im,
   output logic signed [WORD_SIZE-1:0] out1_re,
   output logic signed [WORD_SIZE-1:0] out1_im,
   output logic                        out_valid,
   output logic                        we,
   output logic                        stage_done
);

   localparam int PW = 2 * WORD_SIZE;
   localparam int SW = PW + 1;
   localparam int CW = (BFLY_PER_STAGE > 1) ? $clog2(BFLY_PER_STAGE) : 1;

   localparam logic signed [SW-1:0] RND  = SW'(2 ** (FRAC_BITS - 1));
   localparam logic signed [SW-1:0] SMAX = SW'(2 ** (WORD_SIZE - 1) - 1);
   localparam logic signed [SW-1:0] SMIN = -SW'(2 ** (WORD_SIZE - 1));
   localparam logic [CW-1:0]        CLAST = CW'(BFLY_PER_STAGE - 1);

   function automatic logic signed [WORD_SIZE-1:0] satWord(input logic signed [SW-1:0] x);
      if (x > SMAX)
         satWord = SMAX[WORD_SIZE-1:0];
      else if (x < SMIN)
         satWord = SMIN[WORD_SIZE-1:0];
      else
         satWord = x[WORD_SIZE-1:0];
   endfunction

   logic w_accept;

   logic                 r_inReady;
   logic                 r_s1Valid;
   logic                 r_s2Valid;
   logic                 r_outValid;
   logic                 r_we;
   logic                 r_stageDone;
   logic [CW-1:0]        r_count;

   logic signed [WORD_SIZE-1:0] r_a1Re, r_a1Im;
   logic signed [PW-1:0]        r_pr, r_pi, r_qr, r_qi;
   logic signed [WORD_SIZE-1:0] r_a2Re, r_a2Im;
   logic signed [WORD_SIZE-1:0] r_bwRe, r_bwIm;
   logic signed [WORD_SIZE-1:0] r_out0Re, r_out0Im, r_out1Re, r_out1Im;

   logic signed [PW-1:0] w_bReExt, w_bImExt, w_wReExt, w_wImExt;
   logic signed [SW-1:0] w_bwRe, w_bwIm, w_bwReSh, w_bwImSh;
   logic signed [WORD_SIZE:0] w_sum0Re, w_sum0Im, w_dif1Re, w_dif1Im;

   assign w_accept = in_valid && r_inReady;

   assign w_bReExt = {{WORD_SIZE{in1_re[WORD_SIZE-1]}}, in1_re};
   assign w_bImExt = {{WORD_SIZE{in1_im[WORD_SIZE-1]}}, in1_im};
   assign w_wReExt = {{WORD_SIZE{tw_re[WORD_SIZE-1]}}, tw_re};
   assign w_wImExt = {{WORD_SIZE{tw_im[WORD_SIZE-1]}}, tw_im};

   // Round half-up before the arithmetic shift, then clamp into one word.
   assign w_bwRe   = {r_pr[PW-1], r_pr} - {r_pi[PW-1], r_pi};
   assign w_bwIm   = {r_qr[PW-1], r_qr} + {r_qi[PW-1], r_qi};
   assign w_bwReSh = (w_bwRe + RND) >>> FRAC_BITS;
   assign w_bwImSh = (w_bwIm + RND) >>> FRAC_BITS;

   // One extra bit keeps the sum exact; dropping its LSB is the truncating halve.
   assign w_sum0Re = {r_a2Re[WORD_SIZE-1], r_a2Re} + {r_bwRe[WORD_SIZE-1], r_bwRe};
   assign w_sum0Im = {r_a2Im[WORD_SIZE-1], r_a2Im} + {r_bwIm[WORD_SIZE-1], r_bwIm};
   assign w_dif1Re = {r_a2Re[WORD_SIZE-1], r_a2Re} - {r_bwRe[WORD_SIZE-1], r_bwRe};
   assign w_dif1Im = {r_a2Im[WORD_SIZE-1], r_a2Im} - {r_bwIm[WORD_SIZE-1], r_bwIm};

   // Control path: ready drops for one cycle after every accept so 'we' always toggles low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inReady   <= 1'b1;
         r_s1Valid   <= 1'b0;
         r_s2Valid   <= 1'b0;
         r_outValid  <= 1'b0;
         r_we        <= 1'b0;
         r_stageDone <= 1'b0;
         r_count     <= '0;
      end else begin
         r_inReady   <= !w_accept;
         r_s1Valid   <= w_accept;
         r_s2Valid   <= r_s1Valid;
         r_outValid  <= r_s2Valid;
         r_we        <= r_outValid;
         r_stageDone <= r_outValid && (r_count == CLAST);
         if (r_outValid)
            r_count <= (r_count == CLAST) ? '0 : r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a1Re <= '0;
         r_a1Im <= '0;
         r_pr   <= '0;
         r_pi   <= '0;
         r_qr   <= '0;
         r_qi   <= '0;
      end else if (w_accept) begin
         r_a1Re <= in0_re;
         r_a1Im <= in0_im;
         r_pr   <= w_bReExt * w_wReExt;
         r_pi   <= w_bImExt * w_wImExt;
         r_qr   <= w_bReExt * w_wImExt;
         r_qi   <= w_bImExt * w_wReExt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a2Re <= '0;
         r_a2Im <= '0;
         r_bwRe <= '0;
         r_bwIm <= '0;
      end else if (r_s1Valid) begin
         r_a2Re <= r_a1Re;
         r_a2Im <= r_a1Im;
         r_bwRe <= satWord(w_bwReSh);
         r_bwIm <= satWord(w_bwImSh);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out0Re <= '0;
         r_out0Im <= '0;
         r_out1Re <= '0;
         r_out1Im <= '0;
      end else if (r_s2Valid) begin
         r_out0Re <= w_sum0Re[WORD_SIZE:1];
         r_out0Im <= w_sum0Im[WORD_SIZE:1];
         r_out1Re <= w_dif1Re[WORD_SIZE:1];
         r_out1Im <= w_dif1Im[WORD_SIZE:1];
      end
   end

   assign in_ready   = r_inReady;
   assign out0_re    = r_out0Re;
   assign out0_im    = r_out0Im;
   assign out1_re    = r_out1Re;
   assign out1_im    = r_out1Im;
   assign out_valid  = r_outValid;
   assign we         = r_we;
   assign stage_done = r_stageDone;

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed-vector bench for fft_butterfly_stage: arithmetic table, pipeline timing,
// throughput limit, per-stage counter and mid-flight reset.
module tb_fft_butterfly_stage;

   typedef struct {
      int aRe, aIm, bRe, bIm, wRe, wIm;
      int o0Re, o0Im, o1Re, o1Im;
   } vec_t;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic in_ready;
   logic signed [15:0] in0_re, in0_im, in1_re, in1_im, tw_re, tw_im;
   logic signed [15:0] out0_re, out0_im, out1_re, out1_im;
   logic out_valid, we, stage_done;

   int cmpCount  = 0;
   int failCount = 0;
   int weModel   = 0;
   vec_t vecs[9];

   fft_butterfly_stage #(.WORD_SIZE(16), .FRAC_BITS(14), .BFLY_PER_STAGE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
      .tw_re(tw_re), .tw_im(tw_im),
      .out0_re(out0_re), .out0_im(out0_im), .out1_re(out1_re), .out1_im(out1_im),
      .out_valid(out_valid), .we(we), .stage_done(stage_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      cmpCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic driveVec(input vec_t v, input logic valid);
      in_valid = valid;
      in0_re = 16'(v.aRe); in0_im = 16'(v.aIm);
      in1_re = 16'(v.bRe); in1_im = 16'(v.bIm);
      tw_re  = 16'(v.wRe); tw_im  = 16'(v.wIm);
   endtask

   task automatic checkResult(input string tag, input vec_t v);
      checkOutput({tag, "_out0_re"}, int'(out0_re), v.o0Re);
      checkOutput({tag, "_out0_im"}, int'(out0_im), v.o0Im);
      checkOutput({tag, "_out1_re"}, int'(out1_re), v.o1Re);
      checkOutput({tag, "_out1_im"}, int'(out1_im), v.o1Im);
   endtask

   // Expected stage_done for the 'we' seen now, then advance the butterfly count.
   task automatic checkWeDone(input string tag);
      checkOutput({tag, "_stage_done"}, int'(stage_done), (weModel == 7) ? 1 : 0);
      weModel = (weModel == 7) ? 0 : weModel + 1;
   endtask

   // One accept, then the full latency window: out_valid at k+2, we at k+3.
   task automatic applyStimulus(input string tag, input vec_t v);
      @(negedge clk);
      checkOutput({tag, "_ready_idle"}, int'(in_ready), 1);
      checkOutput({tag, "_we_idle"}, int'(we), 0);
      driveVec(v, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput({tag, "_ready_after_accept"}, int'(in_ready), 0);
      checkOutput({tag, "_early_valid"}, int'({out_valid, we}), 0);
      @(negedge clk);
      checkOutput({tag, "_early_valid2"}, int'({out_valid, we}), 0);
      @(negedge clk);
      checkOutput({tag, "_out_valid"}, int'(out_valid), 1);
      checkOutput({tag, "_we_before"}, int'(we), 0);
      checkOutput({tag, "_done_before"}, int'(stage_done), 0);
      checkResult(tag, v);
      @(negedge clk);
      checkOutput({tag, "_we"}, int'(we), 1);
      checkOutput({tag, "_out_valid_drop"}, int'(out_valid), 0);
      checkWeDone(tag);
      checkResult({tag, "_hold"}, v);
   endtask

   initial begin
      int accepts, wes, dones;
      logic prevWe;

      vecs[0] = '{1000, 200, 400, -100, 16384, 0, 700, 50, 300, 150};
      vecs[1] = '{0, 0, 400, -100, 0, -16384, -50, -200, 50, 200};
      vecs[2] = '{0, 0, -32768, -32768, 16384, -16384, -16384, 0, 16384, 0};
      vecs[3] = '{0, 0, 1, 0, 8192, 0, 0, 0, -1, 0};
      vecs[4] = '{32767, -32768, 0, 0, 0, 0, 16383, -16384, 16383, -16384};
      vecs[5] = '{32767, 32767, 32767, 32767, 16384, 0, 32767, 32767, 0, 0};
      vecs[6] = '{10, 20, 100, -50, -16384, 0, -45, 35, 55, -15};
      vecs[7] = '{3, -3, -1, 0, 8192, 0, 1, -2, 1, -2};
      vecs[8] = '{0, 0, -32768, 0, -16384, 0, 16383, 0, -16384, 0};

      rst_n = 1'b0;
      driveVec(vecs[0], 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", int'(in_ready), 1);
      checkOutput("reset_flags", int'({out_valid, we, stage_done}), 0);
      checkOutput("reset_out0", int'({out0_re, out0_im}), 0);
      checkOutput("reset_out1", int'({out1_re, out1_im}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] Throughput: in_valid held high for 16 cycles");
      accepts = 0; wes = 0; dones = 0; prevWe = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         driveVec(vecs[0], (c < 16) ? 1'b1 : 1'b0);
         if (c < 16)
            checkOutput($sformatf("tp_ready_c%0d", c), int'(in_ready), (c % 2 == 0) ? 1 : 0);
         if (out_valid)
            checkResult("tp", vecs[0]);
         if (we) begin
            wes++;
            checkOutput("tp_we_gap", int'(prevWe), 0);
            checkWeDone($sformatf("tp_we%0d", wes));
         end
         if (stage_done)
            dones++;
         prevWe = we;
         if (in_valid && in_ready)
            accepts++;
      end
      checkOutput("tp_accepts", accepts, 8);
      checkOutput("tp_we_count", wes, 8);
      checkOutput("tp_done_count", dones, 1);

      $display("[TB] Vector table");
      for (int i = 0; i < 9; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i]);

      $display("[TB] Stalled source, one pulse every 5 cycles");
      for (int i = 0; i < 3; i++)
         applyStimulus($sformatf("stall%0d", i), vecs[6 + i]);

      $display("[TB] Reset mid-flight");
      @(negedge clk);
      driveVec(vecs[1], 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out0", int'({out0_re, out0_im}), 0);
      checkOutput("midrst_out1", int'({out1_re, out1_im}), 0);
      checkOutput("midrst_flags", int'({out_valid, we, stage_done}), 0);
      checkOutput("midrst_ready", int'(in_ready), 1);
      weModel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput($sformatf("postrst_quiet_c%0d", c), int'({out_valid, we, stage_done}), 0);
      end
      for (int i = 0; i < 8; i++)
         applyStimulus($sformatf("fresh%0d", i), vecs[i]);
      checkOutput("fresh_done_last", int'(stage_done), 1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
      $finish;
   end

endmodule
